// File: rtl/jesd204b_rx_cgs_pkg.sv
// Shared types and constants for the JESD204B receive code-group synchronisation block.
package jesd204b_rx_cgs_pkg;

  typedef enum logic [1:0] {
    CS_INIT  = 2'd0,
    CS_CHECK = 2'd1,
    CS_DATA  = 2'd2
  } cgs_state_t;

  // K28.5 comma character, decoded octet value
  localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/jesd204b_rx_cgs.sv
// JESD204B receiver code-group synchronisation: drives SYNC~, tracks /K/ runs,
// monitors symbol errors after lock and passes decoded symbols through.
module jesd204b_rx_cgs
  import jesd204b_rx_cgs_pkg::*;
#(
  parameter int unsigned K_CONSEC     = 4,
  parameter int unsigned SYNC_MIN_LOW = 16,
  parameter int unsigned I_LIMIT      = 3,
  parameter int unsigned V_RUN        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_is_k,
  input  logic        in_disp_err,
  input  logic        in_nit_err,
  input  logic        sync_req,
  output logic        sync_n,
  output logic [1:0]  cgs_state,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_is_k,
  output logic        ilas_start,
  output logic [15:0] err_cnt
);

  localparam int unsigned KW = $clog2(K_CONSEC + 2);
  localparam int unsigned LW = $clog2(SYNC_MIN_LOW + 2);
  localparam int unsigned IW = $clog2(I_LIMIT + 2);
  localparam int unsigned VW = $clog2(V_RUN + 2);

  localparam logic [KW-1:0] K_MAX  = KW'(K_CONSEC);
  localparam logic [LW-1:0] LT_MAX = LW'(SYNC_MIN_LOW);
  localparam logic [IW-1:0] I_MAX  = IW'(I_LIMIT);
  localparam logic [VW-1:0] V_MAX  = VW'(V_RUN);

  cgs_state_t    r_state;
  logic          r_sync_n;
  logic [KW-1:0] r_kcnt;
  logic [LW-1:0] r_ltcnt;
  logic [IW-1:0] r_icnt;
  logic [VW-1:0] r_vcnt;
  logic          r_ilas_armed;
  logic          r_ilas_start;
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic          r_out_is_k;
  logic [15:0]   r_err_cnt;

  logic          w_valid;
  logic          w_invalid;
  logic          w_kchar;
  logic          w_in_sync;
  logic [KW-1:0] w_kcnt_inc;
  logic [LW-1:0] w_lt_next;
  logic [IW-1:0] w_icnt_inc;
  logic [IW-1:0] w_icnt_dec;
  logic [VW-1:0] w_vcnt_inc;

  // Symbol classification and saturating/next counter values
  always_comb begin
    w_valid    = in_valid & ~in_disp_err & ~in_nit_err;
    w_invalid  = in_valid & (in_disp_err | in_nit_err);
    w_kchar    = w_valid & in_is_k & (in_data == K28_5);
    w_in_sync  = (r_state == CS_DATA) || (r_state == CS_CHECK);
    w_kcnt_inc = (r_kcnt >= K_MAX) ? r_kcnt : r_kcnt + KW'(1);
    w_lt_next  = (r_ltcnt >= LT_MAX) ? r_ltcnt : r_ltcnt + LW'(1);
    w_icnt_inc = r_icnt + IW'(1);
    w_icnt_dec = r_icnt - IW'(1);
    w_vcnt_inc = r_vcnt + VW'(1);
  end

  // Synchronisation FSM with its counters, SYNC~ and ILAS-start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CS_INIT;
      r_sync_n     <= 1'b0;
      r_kcnt       <= '0;
      r_ltcnt      <= '0;
      r_icnt       <= '0;
      r_vcnt       <= '0;
      r_ilas_armed <= 1'b0;
      r_ilas_start <= 1'b0;
    end else if (sync_req) begin
      r_state      <= CS_INIT;
      r_sync_n     <= 1'b0;
      r_kcnt       <= '0;
      r_ltcnt      <= '0;
      r_icnt       <= '0;
      r_vcnt       <= '0;
      r_ilas_armed <= 1'b0;
      r_ilas_start <= 1'b0;
    end else begin
      r_ilas_start <= 1'b0;
      unique case (r_state)
        CS_INIT: begin
          if (w_kchar) begin
            r_kcnt <= w_kcnt_inc;
          end else if (in_valid) begin
            r_kcnt <= '0;
          end
          // The low-time counter includes the current cycle so that SYNC~ is
          // released on exactly the SYNC_MIN_LOW-th edge spent in CS_INIT.
          if ((r_kcnt >= K_MAX) && (w_lt_next >= LT_MAX)) begin
            r_state      <= CS_DATA;
            r_sync_n     <= 1'b1;
            r_ilas_armed <= 1'b1;
            r_kcnt       <= '0;
            r_ltcnt      <= '0;
          end else begin
            r_ltcnt <= w_lt_next;
          end
        end
        CS_DATA, CS_CHECK: begin
          if (w_valid && !w_kchar && r_ilas_armed) begin
            r_ilas_start <= 1'b1;
            r_ilas_armed <= 1'b0;
          end
          // CS_DATA always holds icnt=0, so one invalid-symbol path serves both states.
          if (w_invalid) begin
            r_vcnt <= '0;
            if (w_icnt_inc >= I_MAX) begin
              r_state      <= CS_INIT;
              r_sync_n     <= 1'b0;
              r_icnt       <= '0;
              r_kcnt       <= '0;
              r_ltcnt      <= '0;
              r_ilas_armed <= 1'b0;
            end else begin
              r_state <= CS_CHECK;
              r_icnt  <= w_icnt_inc;
            end
          end else if (w_valid && (r_state == CS_CHECK)) begin
            if (w_vcnt_inc >= V_MAX) begin
              r_vcnt <= '0;
              r_icnt <= w_icnt_dec;
              if (w_icnt_dec == '0) begin
                r_state <= CS_DATA;
              end
            end else begin
              r_vcnt <= w_vcnt_inc;
            end
          end
        end
        default: begin
          r_state      <= CS_INIT;
          r_sync_n     <= 1'b0;
          r_kcnt       <= '0;
          r_ltcnt      <= '0;
          r_icnt       <= '0;
          r_vcnt       <= '0;
          r_ilas_armed <= 1'b0;
        end
      endcase
    end
  end

  // Registered symbol pass-through and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_is_k  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_out_valid <= in_valid & w_in_sync;
      r_out_data  <= in_data;
      r_out_is_k  <= in_is_k;
      if (w_invalid && w_in_sync && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign sync_n     = r_sync_n;
  assign cgs_state  = r_state;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_is_k   = r_out_is_k;
  assign ilas_start = r_ilas_start;
  assign err_cnt    = r_err_cnt;

endmodule

// File: doc/jesd204b_rx_cgs.md
JESD204B_RX_CGS -- requirements
Module: jesd204b_rx_cgs

Interface
REQ-001 Parameter K_CONSEC, default 4, number of consecutive valid /K/ (K28.5) symbols required to leave CS_INIT.
REQ-002 Parameter SYNC_MIN_LOW, default 16, minimum clock cycles sync_n SHALL stay low after entering CS_INIT.
REQ-003 Parameter I_LIMIT, default 3, invalid-symbol count in CS_CHECK that returns the block to CS_INIT.
REQ-004 Parameter V_RUN, default 4, consecutive valid symbols in CS_CHECK that decrement the invalid count by one.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  decoded symbol present this cycle (from 8b10b decoder).
REQ-008 in_data  input  8  decoded octet HGFEDCBA.
REQ-009 in_is_k  input  1  symbol is a control (K) character.
REQ-010 in_disp_err  input  1  running-disparity error on this symbol.
REQ-011 in_nit_err  input  1  10-bit code not in table.
REQ-012 sync_req  input  1  level; forces re-synchronisation.
REQ-013 sync_n  output  1  JESD204B SYNC~, low requests CGS.
REQ-014 cgs_state  output  2  current state encoding from package.
REQ-015 out_valid, out_data[7:0], out_is_k  output  1/8/1  registered symbol pass-through.
REQ-016 ilas_start  output  1  one-cycle pulse on first non-/K/ valid symbol after leaving CS_INIT.
REQ-017 err_cnt  output  16  saturating count of invalid symbols seen in CS_DATA/CS_CHECK.

Function
REQ-018 Valid symbol = in_valid & ~in_disp_err & ~in_nit_err; /K/ = valid & in_is_k & in_data==8'hBC.
REQ-019 Cycles with in_valid=0 SHALL not change any counter or state except the low-time counter.
REQ-020 CS_INIT: sync_n=0; /K/ increments kcnt (saturating at K_CONSEC); any other valid or invalid symbol clears kcnt.
REQ-021 CS_INIT -> CS_DATA when kcnt>=K_CONSEC and low-time counter>=SYNC_MIN_LOW, evaluated every cycle; sync_n goes 1 in the same cycle cgs_state shows CS_DATA.
REQ-022 CS_DATA: sync_n=1; invalid symbol -> CS_CHECK with icnt=1, vcnt=0.
REQ-023 CS_CHECK: invalid symbol -> icnt+1, vcnt=0; reaching I_LIMIT -> CS_INIT, kcnt=0, low-time counter=0.
REQ-024 CS_CHECK: valid symbol -> vcnt+1; on reaching V_RUN, vcnt=0 and icnt-1; icnt reaching 0 -> CS_DATA.
REQ-025 sync_req=1 in any state -> CS_INIT next cycle, counters cleared; held high keeps CS_INIT and low-time counter at 0.
REQ-026 out_valid/out_data/out_is_k: 1-cycle registered copy of input, out_valid=in_valid only when state at sample was CS_DATA or CS_CHECK.
REQ-027 ilas_start: pulses with the out_valid of the first valid non-/K/ symbol after CS_INIT exit; at most once per sync cycle.
REQ-028 err_cnt increments on each invalid symbol in CS_DATA/CS_CHECK, saturates at 16'hFFFF, cleared only by reset.
REQ-029 Low-time counter saturates at SYNC_MIN_LOW; no wrap.

Reset
REQ-030 While rst_n=0: state=CS_INIT, sync_n=0, all counters 0, out_valid=0, out_data=0, out_is_k=0, ilas_start=0, err_cnt=0.
REQ-031 Reset assertion mid-CS_DATA SHALL immediately (asynchronously) drive sync_n=0.

Structure
REQ-032 Package jesd204b_rx_cgs_pkg holds the state enum (CS_INIT=0, CS_CHECK=1, CS_DATA=2) and constant K28_5=8'hBC.
REQ-033 Single module, no sub-modules; one FSM process plus registered output stage.

Verification
REQ-034 Reset release, 20 consecutive /K/ -> sync_n rises exactly cycle 16 after reset release (SYNC_MIN_LOW governs), state CS_DATA.
REQ-035 3 /K/, one D21.5 (8'hB5), 4 /K/ after min-low elapsed -> sync_n rises after 4th /K/ of second run only.
REQ-036 In CS_DATA: 2 disp errors then 8 valid D symbols -> CS_CHECK, icnt 2->1->0, back to CS_DATA; sync_n stays 1; err_cnt=2.
REQ-037 In CS_DATA: 3 nit errors separated by 1 valid symbol each -> CS_INIT on third, sync_n=0 next cycle.
REQ-038 After sync, /K/ x4 then 8'h1C (K28.0, is_k=1) -> ilas_start single pulse aligned with that out_valid.
REQ-039 sync_req pulse mid CS_DATA, and async rst_n mid-stream -> CS_INIT, sync_n=0, min-low time re-enforced.
